// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one DataMem port between instruction fetch and load/store.
// LS normally wins; a starvation counter forces an IF win after STARVE_MAX
// consecutive LS grants taken while IF was waiting. Each transaction owns the
// port for MEM_LAT cycles, and its completion cycle may overlap the next grant.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int LW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {NONE, OWN_IF, OWN_LS} owner_t;
  state_t          state;
  owner_t          owner;
  logic            owner_we;
  logic [LW-1:0]   lat_cnt;
  logic [SW-1:0]   starve_cnt;
  logic            last, grant_ok, force_if, if_win, ls_win, done;
  // The final BUSY cycle is both the completion cycle and a grant slot.
  assign last     = state == BUSY && lat_cnt == LW'(1);
  assign grant_ok = reset && (state == IDLE || last);
  assign force_if = starve_cnt == SW'(STARVE_MAX);
  assign if_win   = grant_ok && if_req && (force_if || !ls_req);
  assign ls_win   = grant_ok && ls_req && !(if_req && force_if);
  assign done     = reset && last;
  assign if_gnt    = if_win;
  assign ls_gnt    = ls_win;
  assign if_rvalid = done && owner == OWN_IF;
  assign ls_rvalid = done && owner == OWN_LS;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = (ls_rvalid && !owner_we) ? mem_rdata : '0;
  assign mem_re    = if_win || (ls_win && !ls_we);
  assign mem_we    = ls_win && ls_we;
  assign mem_addr  = if_win ? if_addr : ls_win ? ls_addr : '0;
  assign mem_wdata = mem_we ? ls_wdata : '0;
  assign busy      = state == BUSY;
  // Port ownership FSM, latency countdown and IF starvation tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= NONE;
      owner_we   <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      if (if_win || ls_win) begin
        state    <= BUSY;
        lat_cnt  <= LW'(MEM_LAT);
        owner    <= if_win ? OWN_IF : OWN_LS;
        owner_we <= ls_win && ls_we;
      end else if (last) begin
        state    <= IDLE;
        lat_cnt  <= '0;
        owner    <= NONE;
        owner_we <= 1'b0;
      end else if (state == BUSY) begin
        lat_cnt <= lat_cnt - LW'(1);
      end
      starve_cnt <= (!if_req || if_win) ? '0 :
                    (ls_win && !force_if) ? starve_cnt + SW'(1) : starve_cnt;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run against a cycle-level reference model.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int SM  = 4;
  localparam int OW  = 3 * DW + AW + 7;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [AW-1:0] if_addr = '0, ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0, mem_rdata = '0;
  logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_re, mem_we, busy;
  logic [DW-1:0] if_rdata, ls_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [OW-1:0] outs;
  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  assign outs = {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
                 mem_addr, mem_re, mem_we, mem_wdata, busy};

  always #5 clk = ~clk;

  task automatic clear_inputs();
    if_req = 0; ls_req = 0; ls_we = 0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0; mem_rdata = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 0; if_req = 1; ls_req = 1; ls_we = 1;
    if_addr = 32'h44; ls_addr = 32'h88; ls_wdata = 32'h1234; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
    @(negedge clk);
    clear_inputs();
    reset = 1;
    #1;
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL idle_after_reset: got %h want 0", outs); end
  endtask

  task automatic test_if_read();
    @(negedge clk);
    if_req = 1; if_addr = 32'h40; mem_rdata = 32'h0050_0093;
    #1;
    n_cmp++;
    if ({if_gnt, ls_gnt, mem_re, mem_we, mem_addr} !== {4'b1010, 32'h40}) begin
      n_bad++; $display("FAIL if_read_cmd: got %b %b %b %b %h want 1 0 1 0 40", if_gnt, ls_gnt, mem_re, mem_we, mem_addr);
    end
    @(negedge clk);
    if_req = 0; if_addr = '0;
    #1;
    n_cmp++;
    if ({busy, if_rvalid, if_gnt} !== 3'b100) begin
      n_bad++; $display("FAIL if_read_wait: got busy/rvalid/gnt %b%b%b want 100", busy, if_rvalid, if_gnt);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({if_rvalid, if_rdata, busy} !== {1'b1, 32'h0050_0093, 1'b1}) begin
      n_bad++; $display("FAIL if_read_data: got rvalid %b rdata %h busy %b want 1 00500093 1", if_rvalid, if_rdata, busy);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, if_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL if_read_idle: got busy %b rvalid %b want 0 0", busy, if_rvalid);
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    if_req = 1; if_addr = 32'h300; ls_req = 1; ls_we = 0; ls_addr = 32'h100;
    #1;
    n_cmp++;
    if ({ls_gnt, if_gnt, mem_re, mem_addr} !== {3'b101, 32'h100}) begin
      n_bad++; $display("FAIL prio_ls_first: got ls %b if %b re %b addr %h want 1 0 1 100", ls_gnt, if_gnt, mem_re, mem_addr);
    end
    @(negedge clk);
    ls_req = 0; ls_addr = '0;
    #1;
    n_cmp++;
    if ({if_gnt, ls_gnt, mem_re} !== 3'b000) begin
      n_bad++; $display("FAIL prio_no_grant_busy: got if %b ls %b re %b want 0 0 0", if_gnt, ls_gnt, mem_re);
    end
    @(negedge clk);
    mem_rdata = 32'h1111_2222;
    #1;
    n_cmp++;
    if ({ls_rvalid, ls_rdata, if_gnt, mem_addr, if_rvalid} !== {1'b1, 32'h1111_2222, 1'b1, 32'h300, 1'b0}) begin
      n_bad++; $display("FAIL prio_if_second: got lsv %b lsd %h ifg %b addr %h ifv %b want 1 11112222 1 300 0",
                        ls_rvalid, ls_rdata, if_gnt, mem_addr, if_rvalid);
    end
    @(negedge clk);
    if_req = 0; if_addr = '0;
    @(negedge clk);
    mem_rdata = 32'h3333_4444;
    #1;
    n_cmp++;
    if ({if_rvalid, if_rdata, ls_rvalid} !== {1'b1, 32'h3333_4444, 1'b0}) begin
      n_bad++; $display("FAIL prio_if_data: got ifv %b ifd %h lsv %b want 1 33334444 0", if_rvalid, if_rdata, ls_rvalid);
    end
    idle(2);
  endtask

  task automatic test_starve();
    string log = "";
    bit drop = 0;
    @(negedge clk);
    if_req = 1; if_addr = 32'h500; ls_req = 1; ls_we = 0; ls_addr = 32'h600;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      if (drop) begin if_req = 0; drop = 0; end
      #1;
      if (if_gnt) begin log = {log, "I"}; drop = 1; end
      else if (ls_gnt) log = {log, "L"};
    end
    n_cmp++;
    if (log != "LLLLILL") begin n_bad++; $display("FAIL starve_order: got %s want LLLLILL", log); end
    idle(3);
  endtask

  task automatic test_write();
    @(negedge clk);
    ls_req = 1; ls_we = 1; ls_addr = 32'h200; ls_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h7777_7777;
    #1;
    n_cmp++;
    if ({ls_gnt, mem_we, mem_re, mem_addr, mem_wdata} !== {3'b110, 32'h200, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL write_cmd: got gnt %b we %b re %b addr %h wdata %h want 1 1 0 200 deadbeef",
                        ls_gnt, mem_we, mem_re, mem_addr, mem_wdata);
    end
    @(negedge clk);
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
    #1;
    n_cmp++;
    if ({mem_we, mem_wdata, ls_rvalid} !== '0) begin
      n_bad++; $display("FAIL write_quiet: got we %b wdata %h rvalid %b want 0 0 0", mem_we, mem_wdata, ls_rvalid);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({ls_rvalid, ls_rdata, if_rvalid} !== {1'b1, 32'h0, 1'b0}) begin
      n_bad++; $display("FAIL write_ack: got rvalid %b rdata %h ifv %b want 1 0 0", ls_rvalid, ls_rdata, if_rvalid);
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if_req = 1; if_addr = 32'h80;
    #1;
    n_cmp++;
    if (if_gnt !== 1'b1) begin n_bad++; $display("FAIL rstmid_grant: got %b want 1", if_gnt); end
    @(negedge clk);
    reset = 0; if_addr = 32'h84; mem_rdata = 32'h5;
    #1;
    n_cmp++;
    if (outs !== '0) begin n_bad++; $display("FAIL rstmid_outputs: got %h want 0", outs); end
    @(negedge clk);
    reset = 1;
    #1;
    n_cmp++;
    if ({if_gnt, if_rvalid, busy, mem_addr} !== {3'b100, 32'h84}) begin
      n_bad++; $display("FAIL rstmid_fresh: got gnt %b rvalid %b busy %b addr %h want 1 0 0 84", if_gnt, if_rvalid, busy, mem_addr);
    end
    @(negedge clk);
    if_req = 0; if_addr = '0;
    @(negedge clk);
    mem_rdata = 32'h9;
    #1;
    n_cmp++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h9}) begin
      n_bad++; $display("FAIL rstmid_data: got rvalid %b rdata %h want 1 9", if_rvalid, if_rdata);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ls_req = 1; ls_we = 0; ls_addr = 32'h110;
    #1;
    n_cmp++;
    if ({ls_gnt, mem_re} !== 2'b11) begin n_bad++; $display("FAIL b2b_ls_grant: got gnt %b re %b want 1 1", ls_gnt, mem_re); end
    @(negedge clk);
    ls_req = 0; ls_addr = '0;
    @(negedge clk);
    if_req = 1; if_addr = 32'h120; mem_rdata = 32'hABC;
    #1;
    n_cmp++;
    if ({ls_rvalid, ls_rdata, if_gnt, mem_re, mem_we, mem_addr} !== {1'b1, 32'hABC, 3'b110, 32'h120}) begin
      n_bad++; $display("FAIL b2b_if_overlap: got lsv %b lsd %h ifg %b re %b we %b addr %h want 1 abc 1 1 0 120",
                        ls_rvalid, ls_rdata, if_gnt, mem_re, mem_we, mem_addr);
    end
    @(negedge clk);
    if_req = 0; if_addr = '0;
    #1;
    n_cmp++;
    if ({mem_re, mem_we} !== 2'b00) begin n_bad++; $display("FAIL b2b_gap: got re %b we %b want 0 0", mem_re, mem_we); end
    @(negedge clk);
    ls_req = 1; ls_we = 1; ls_addr = 32'h130; ls_wdata = 32'h55; mem_rdata = 32'hDEF;
    #1;
    n_cmp++;
    if ({if_rvalid, if_rdata, ls_gnt, mem_we, mem_re, mem_wdata} !== {1'b1, 32'hDEF, 3'b110, 32'h55}) begin
      n_bad++; $display("FAIL b2b_ls_overlap: got ifv %b ifd %h lsg %b we %b re %b wd %h want 1 def 1 1 0 55",
                        if_rvalid, if_rdata, ls_gnt, mem_we, mem_re, mem_wdata);
    end
    @(negedge clk);
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({ls_rvalid, ls_rdata} !== {1'b1, 32'h0}) begin
      n_bad++; $display("FAIL b2b_write_ack: got rvalid %b rdata %h want 1 0", ls_rvalid, ls_rdata);
    end
    idle(3);
  endtask

  task automatic test_random();
    int comp_who = 0, comp_at = 0, starve = 0;
    bit comp_we = 0, e_ifg = 0, e_lsg = 0, ok, done, e_mre, e_mwe;
    logic [OW-1:0] exp;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 49) != 0);
      mem_rdata = $urandom();
      if (if_req && !e_ifg) begin
        if ($urandom_range(0, 15) == 0) if_req = 0;
      end else begin
        if_req = $urandom_range(0, 1); if_addr = $urandom();
      end
      if (ls_req && !e_lsg) begin
        if ($urandom_range(0, 15) == 0) ls_req = 0;
      end else begin
        ls_req = $urandom_range(0, 2) != 0; ls_we = $urandom_range(0, 1);
        ls_addr = $urandom(); ls_wdata = $urandom();
      end
      #1;
      ok    = comp_who == 0 || cyc == comp_at;
      e_ifg = reset && ok && if_req && (starve == SM || !ls_req);
      e_lsg = reset && ok && ls_req && !e_ifg;
      done  = reset && comp_who != 0 && cyc == comp_at;
      e_mre = e_ifg || (e_lsg && !ls_we);
      e_mwe = e_lsg && ls_we;
      exp = {e_ifg, done && comp_who == 1, (done && comp_who == 1) ? mem_rdata : 32'h0,
             e_lsg, done && comp_who == 2, (done && comp_who == 2 && !comp_we) ? mem_rdata : 32'h0,
             e_ifg ? if_addr : (e_lsg ? ls_addr : 32'h0), e_mre, e_mwe, e_mwe ? ls_wdata : 32'h0,
             reset && comp_who != 0};
      n_cmp++;
      if (outs !== exp) begin
        n_bad++; $display("FAIL random_cycle %0d: got %h want %h", cyc, outs, exp);
      end
      if (!reset) begin
        comp_who = 0; starve = 0;
      end else begin
        if (done) comp_who = 0;
        if (e_ifg || e_lsg) begin
          comp_who = e_ifg ? 1 : 2; comp_at = cyc + LAT; comp_we = e_lsg && ls_we;
        end
        starve = (!if_req || e_ifg) ? 0 : (e_lsg && starve < SM) ? starve + 1 : starve;
      end
    end
    @(negedge clk);
    reset = 1;
    idle(3);
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_priority();
    test_starve();
    test_write();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
